display_scan_ctrl: RTL

//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   A single hex-to-segment decoder is shared across all digits.

---
 rtl/display_scan_ctrl_pkg.sv | 25 ++
 rtl/display_scan_ctrl_if.sv | 28 ++
 rtl/display_scan_ctrl_seg7_hex_dec.sv | 35 +++
 rtl/display_scan_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared segment codes for the display scan controller (active-low, bit6=g .. bit0=a).
// Latency: none, constants only.
// Backpressure: none.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_C = 7'b100_0110;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// User-side and pin-side signals of the display scan controller.
// Latency: none, wiring only.
// Backpressure: none; load is a fire-and-forget strobe.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] x;
  logic                  load;
  logic                  lz_en;
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   dp_in;
  logic [6:0]            a_to_g;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;

  // User logic side: drives digit data and controls, watches the pins.
  modport master (
    output x, load, lz_en, blank, dp_in,
    input  a_to_g, dp, an, frame_done
  );

  // Controller side.
  modport slave (
    input  x, load, lz_en, blank, dp_in,
    output a_to_g, dp, an, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl_seg7_hex_dec.sv
// Hex nibble to active-low 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
module display_scan_ctrl_seg7_hex_dec
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup; every nibble value is covered.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of an N-digit common-anode display with frame-aligned double buffering.
// Latency: pins follow the digit index by 1 clk; a load becomes visible at the next frame start.
// Backpressure: none; extra loads within a frame overwrite the pending value.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             clr,
  display_scan_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam int XW = 4 * N_DIGITS;
  localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [XW-1:0]       active_q, active_d;
  logic [XW-1:0]       pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic       suppressed;
  logic       digit_off;
  logic [3:0] dec_in;
  logic [6:0] dec_out;

  // Single decoder shared by all digits; its input follows the scan index.
  display_scan_ctrl_seg7_hex_dec u_dec (
    .hex (dec_in),
    .seg (dec_out)
  );

  // Next-state for prescaler, scan index, double buffer and pin registers.
  always_comb begin
    tick = (cnt_q == CNT_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Swap into the active buffer only on the frame wrap so a frame never mixes values;
    // a load on the wrap cycle itself is newer than anything pending.
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (bus.load && !wrap) begin
      pend_d   = bus.x;
      pend_v_d = 1'b1;
    end else if (wrap && bus.load) begin
      active_d = bus.x;
      pend_v_d = 1'b0;
    end else if (wrap && pend_v_q) begin
      active_d = pend_q;
      pend_v_d = 1'b0;
    end

    // Digit idx is a leading zero when it and every more-significant nibble are zero.
    suppressed = bus.lz_en && (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
    digit_off  = bus.blank[idx_q] || suppressed;
    dec_in     = active_q[{idx_q, 2'b00} +: 4];

    // The anode stays enabled on an off digit so the scan duty cycle is unchanged.
    an_d         = ~(AN_ONE << idx_q);
    seg_d        = digit_off ? SEG_BLANK : dec_out;
    dp_d         = digit_off ? 1'b1 : ~bus.dp_in[idx_q];
    frame_done_d = wrap;
  end

  // State and pin registers; clr wins over every other input.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.a_to_g     = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
